mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and MEM-stage
// loads/stores onto one byte-wide synchronous RAM port (MEM has priority).
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    input  logic        mem_req_in,
    input  logic        mem_we_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [1:0]  mem_width_in,
    input  logic        branch_flag_in,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic        if_done_out,
    output logic [31:0] if_inst_out,
    output logic        mem_done_out,
    output logic [31:0] mem_rdata_out,
    output logic        stallreq_if_out,
    output logic        stallreq_mem_out
);
    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  width_q, width_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic [2:0]  n_bytes;
    logic [2:0]  off;
    logic [1:0]  lane;
    logic [31:0] word_c;
    logic        if_done_c, mem_done_c, mem_rd_done_c;
    logic [31:0] ram_a_c;
    logic [7:0]  ram_dout_c;
    logic        ram_wr_c;

    always_comb begin
        case (width_q)
            2'b00:   n_bytes = 3'd1;
            2'b01:   n_bytes = 3'd2;
            default: n_bytes = 3'd4;
        endcase
    end

    // While frozen (and in the final capture cycle) re-drive the last issued
    // address so ram_din still carries the byte still owed to the buffer.
    always_comb begin
        off = cnt_q;
        if (cnt_q != 3'd0 && (!rdy_in || cnt_q == n_bytes))
            off = cnt_q - 3'd1;
    end

    // Byte issued last cycle lands in lane cnt-1 (cnt=4 wraps to lane 3).
    always_comb begin
        lane   = cnt_q[1:0] - 2'd1;
        word_c = buf_q;
        word_c[{lane, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        width_d       = width_q;
        buf_d         = buf_q;
        if_inst_d     = if_inst_q;
        mem_rdata_d   = mem_rdata_q;
        ram_a_c       = 32'd0;
        ram_dout_c    = 8'd0;
        ram_wr_c      = 1'b0;
        if_done_c     = 1'b0;
        mem_done_c    = 1'b0;
        mem_rd_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (rdy_in) begin
                    if (mem_req_in) begin
                        state_d = mem_we_in ? MEM_WR : MEM_RD;
                        addr_d  = mem_addr_in;
                        wdata_d = mem_wdata_in;
                        width_d = mem_width_in;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                    end else if (if_req_in && !branch_flag_in) begin
                        state_d = IF_RD;
                        addr_d  = if_addr_in;
                        width_d = 2'b10;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                    end
                end
            end
            IF_RD, MEM_RD: begin
                ram_a_c = addr_q + {29'd0, off};
                if (rdy_in) begin
                    if (state_q == IF_RD && branch_flag_in) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        if (cnt_q != 3'd0)
                            buf_d = word_c;
                        if (cnt_q == n_bytes) begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                            if (state_q == IF_RD) begin
                                if_done_c = 1'b1;
                                if_inst_d = word_c;
                            end else begin
                                mem_done_c    = 1'b1;
                                mem_rd_done_c = 1'b1;
                                mem_rdata_d   = word_c;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
            end
            MEM_WR: begin
                ram_a_c    = addr_q + {29'd0, cnt_q};
                ram_dout_c = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                ram_wr_c   = rdy_in;
                if (rdy_in) begin
                    if (cnt_q == n_bytes - 3'd1) begin
                        state_d    = IDLE;
                        cnt_d      = 3'd0;
                        mem_done_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            width_q     <= 2'b00;
            buf_q       <= 32'd0;
            if_inst_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            width_q     <= width_d;
            buf_q       <= buf_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Completion data is visible in the done cycle itself, then held.
    assign ram_a            = ram_a_c;
    assign ram_dout         = ram_dout_c;
    assign ram_wr           = ram_wr_c;
    assign if_done_out      = if_done_c;
    assign if_inst_out      = if_done_c ? word_c : if_inst_q;
    assign mem_done_out     = mem_done_c;
    assign mem_rdata_out    = mem_rd_done_c ? word_c : mem_rdata_q;
    assign stallreq_if_out  = rst_in & if_req_in & ~if_done_c;
    assign stallreq_mem_out = rst_in & mem_req_in & ~mem_done_c;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-RAM model, completion scoreboards, and
// cycle-exact checks of fetch, contention, store, abort, stall and reset.
module tb_mem_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        if_req_in, mem_req_in, mem_we_in, branch_flag_in;
    logic [31:0] if_addr_in, mem_addr_in, mem_wdata_in;
    logic [1:0]  mem_width_in;
    logic [7:0]  ram_din, ram_dout;
    logic [31:0] ram_a, if_inst_out, mem_rdata_out;
    logic        ram_wr, if_done_out, mem_done_out;
    logic        stallreq_if_out, stallreq_mem_out;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [31:0] if_q[$];
    logic [31:0] mem_q[$];
    logic [7:0]  ram_m[logic [31:0]];

    always #5 clk_in = ~clk_in;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_addr_in(mem_addr_in),
        .mem_wdata_in(mem_wdata_in), .mem_width_in(mem_width_in),
        .branch_flag_in(branch_flag_in),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .if_done_out(if_done_out), .if_inst_out(if_inst_out),
        .mem_done_out(mem_done_out), .mem_rdata_out(mem_rdata_out),
        .stallreq_if_out(stallreq_if_out), .stallreq_mem_out(stallreq_mem_out)
    );

    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram_m.exists(a) ? ram_m[a] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Synchronous byte RAM: read data valid one cycle after the address.
    always @(posedge clk_in) begin
        ram_din <= rd(ram_a);
        if (ram_wr) ram_m[ram_a] = ram_dout;
    end

    always @(negedge clk_in) begin
        if (ram_wr) wr_cnt++;
        if (if_done_out) begin
            if (if_q.size() == 0) chk("if_done_unexpected", 32'd1, 32'd0);
            else chk("if_inst", if_inst_out, if_q.pop_front());
        end
        if (mem_done_out) begin
            if (mem_q.size() == 0) chk("mem_done_unexpected", 32'd1, 32'd0);
            else chk("mem_rdata", mem_rdata_out, mem_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_in);
    endtask

    initial begin
        int base_wr;
        rst_in = 1'b0; rdy_in = 1'b1; branch_flag_in = 1'b0;
        if_req_in = 1'b1; if_addr_in = 32'h100;
        mem_req_in = 1'b1; mem_we_in = 1'b1; mem_addr_in = 32'h40;
        mem_wdata_in = 32'hFFFF_FFFF; mem_width_in = 2'b10;
        ram_m[32'h100] = 8'h13; ram_m[32'h101] = 8'h05;
        ram_m[32'h102] = 8'h00; ram_m[32'h103] = 8'h00;
        ram_m[32'h200] = 8'h78; ram_m[32'h201] = 8'h56;
        ram_m[32'h202] = 8'h34; ram_m[32'h203] = 8'h12;
        ram_m[32'h3FE] = 8'hCD; ram_m[32'h3FF] = 8'hAB;

        // Held in reset with both requests high.
        step(); step(); smp();
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rst_stall_if", {31'd0, stallreq_if_out}, 32'd0);
        chk("rst_stall_mem", {31'd0, stallreq_mem_out}, 32'd0);
        chk("rst_inst", if_inst_out, 32'd0);
        chk("rst_rdata", mem_rdata_out, 32'd0);
        step(); if_req_in = 0; mem_req_in = 0; mem_we_in = 0; rst_in = 1'b1;
        step();

        // Instruction fetch of 0x100.
        step(); if_req_in = 1; if_addr_in = 32'h100; if_q.push_back(32'h0000_0513);
        smp(); chk("a_stall_c0", {31'd0, stallreq_if_out}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step(); smp();
            chk("a_if_done", {31'd0, if_done_out}, {31'd0, k == 5});
            if (k <= 4) chk("a_ram_a", ram_a, 32'h100 + k - 1);
            else chk("a_stall_c5", {31'd0, stallreq_if_out}, 32'd0);
        end
        step(); if_req_in = 0; smp();
        chk("a_hold_inst", if_inst_out, 32'h0000_0513);
        chk("a_idle_a", ram_a, 32'd0);

        // Contention: load word wins, fetch is served afterwards.
        step(); mem_req_in = 1; mem_we_in = 0; mem_addr_in = 32'h200; mem_width_in = 2'b10;
        if_req_in = 1; if_addr_in = 32'h100;
        mem_q.push_back(32'h1234_5678); if_q.push_back(32'h0000_0513);
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 6) mem_req_in = 0;
            smp();
            chk("b_mem_done", {31'd0, mem_done_out}, {31'd0, c == 5});
            chk("b_if_done", {31'd0, if_done_out}, {31'd0, c == 11});
            if (c == 1) chk("b_ram_a_mem", ram_a, 32'h200);
            if (c == 7) chk("b_ram_a_if", ram_a, 32'h100);
        end
        step(); if_req_in = 0; smp();
        chk("b_hold_rdata", mem_rdata_out, 32'h1234_5678);

        // Store byte: only byte 0 of wdata goes out, one write pulse.
        step(); base_wr = wr_cnt;
        mem_req_in = 1; mem_we_in = 1; mem_width_in = 2'b00;
        mem_addr_in = 32'h0003_0004; mem_wdata_in = 32'hDEAD_BE41;
        mem_q.push_back(32'h1234_5678);
        smp(); chk("c_no_wr_idle", {31'd0, ram_wr}, 32'd0);
        step(); smp();
        chk("c_ram_wr", {31'd0, ram_wr}, 32'd1);
        chk("c_ram_a", ram_a, 32'h0003_0004);
        chk("c_ram_dout", {24'd0, ram_dout}, 32'h41);
        chk("c_mem_done", {31'd0, mem_done_out}, 32'd1);
        step(); mem_req_in = 0; mem_we_in = 0; smp();
        chk("c_wr_off", {31'd0, ram_wr}, 32'd0);
        chk("c_wr_count", wr_cnt - base_wr, 32'd1);
        chk("c_ram_byte", {24'd0, rd(32'h0003_0004)}, 32'h41);

        // Branch on the accept cycle suppresses the fetch.
        step(); if_req_in = 1; if_addr_in = 32'h100; branch_flag_in = 1; smp();
        step(); if_req_in = 0; branch_flag_in = 0; smp();
        chk("g_stay_idle", ram_a, 32'd0);
        step();

        // Branch abort at cycle 2 of a fetch, redirected fetch at cycle 3.
        step(); if_req_in = 1; if_addr_in = 32'h100; smp();
        step(); smp(); chk("d_ram_a_c1", ram_a, 32'h100);
        step(); branch_flag_in = 1; if_addr_in = 32'h200; smp();
        chk("d_latched_a", ram_a, 32'h101);
        step(); branch_flag_in = 0; if_q.push_back(32'h1234_5678); smp();
        chk("d_idle_c3", ram_a, 32'd0);
        for (int c = 4; c <= 8; c++) begin
            step(); smp();
            chk("d_if_done", {31'd0, if_done_out}, {31'd0, c == 8});
            if (c == 4) chk("d_ram_a_c4", ram_a, 32'h200);
        end
        step(); if_req_in = 0; smp();

        // Halfword load with a two-cycle rdy_in freeze.
        step(); mem_req_in = 1; mem_we_in = 0; mem_width_in = 2'b01; mem_addr_in = 32'h3FE;
        mem_q.push_back(32'h0000_ABCD);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 2) rdy_in = 0;
            if (c == 4) rdy_in = 1;
            if (c == 6) mem_req_in = 0;
            smp();
            chk("e_mem_done", {31'd0, mem_done_out}, {31'd0, c == 5});
            chk("e_ram_wr", {31'd0, ram_wr}, 32'd0);
            if (c == 1) chk("e_ram_a", ram_a, 32'h3FE);
        end

        // Reset asserted in cycle 2 of a word store.
        step(); base_wr = wr_cnt;
        mem_req_in = 1; mem_we_in = 1; mem_width_in = 2'b10;
        mem_addr_in = 32'h500; mem_wdata_in = 32'hA1B2_C3D4;
        step(); smp();
        chk("f_wr_c1", {31'd0, ram_wr}, 32'd1);
        step(); #1;
        chk("f_wr_c2", {31'd0, ram_wr}, 32'd1);
        rst_in = 0; #1;
        chk("f_rst_wr", {31'd0, ram_wr}, 32'd0);
        chk("f_rst_a", ram_a, 32'd0);
        chk("f_rst_stall", {31'd0, stallreq_mem_out}, 32'd0);
        step(); mem_req_in = 0; mem_we_in = 0;
        step(); rst_in = 1; if_req_in = 1; if_addr_in = 32'h100;
        if_q.push_back(32'h0000_0513);
        smp(); chk("f_idle_rel", ram_a, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            step(); smp();
            chk("f_if_done", {31'd0, if_done_out}, {31'd0, c == 5});
            if (c == 1) chk("f_resume_a", ram_a, 32'h100);
        end
        step(); if_req_in = 0; smp();
        chk("f_wr_count", wr_cnt - base_wr, 32'd1);
        chk("f_byte0", {24'd0, rd(32'h500)}, 32'hD4);
        chk("f_byte1", {24'd0, rd(32'h501)}, 32'h00);

        chk("if_q_empty", if_q.size(), 32'd0);
        chk("mem_q_empty", mem_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
